// File: rtl/bcd_display_scan.sv
// Four-position multiplexed seven-segment driver for a signed three-digit BCD value.
// Captured values are held pending and only take effect on frame boundaries.
module bcd_display_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] in_ones,
  input  logic [3:0] in_tens,
  input  logic [3:0] in_huns,
  input  logic       in_negative,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       ready,
  output logic       err
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_ERR   = 7'b0000110;

  typedef struct packed {
    logic       neg;
    logic [3:0] huns;
    logic [3:0] tens;
    logic [3:0] ones;
  } value_t;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  value_t           pend;
  value_t           act;
  value_t           in_val;
  logic             last_cnt;
  logic             boundary;

  logic [6:0] seg_nxt;
  logic [3:0] an_nxt;
  logic       err_nxt;
  logic       huns_blank;
  logic       tens_blank;
  logic       mag_nz;

  // Active-low glyph for one BCD digit; anything above 9 renders as 'E'.
  function automatic logic [6:0] digit_code(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = SEG_ERR;
    endcase
    return code;
  endfunction

  assign in_val   = '{neg: in_negative, huns: in_huns, tens: in_tens, ones: in_ones};
  assign last_cnt = (cnt == CNT_MAX);
  assign boundary = last_cnt && (idx == 2'd3);

  // Glyph selection for the position currently indexed, from the active value.
  always_comb begin
    seg_nxt    = SEG_BLANK;
    huns_blank = (act.huns == 4'd0);
    tens_blank = huns_blank && (act.tens == 4'd0);
    mag_nz     = |{act.huns, act.tens, act.ones};
    an_nxt     = ~(4'b0001 << idx);
    err_nxt    = (act.ones > 4'd9) || (act.tens > 4'd9) || (act.huns > 4'd9);
    case (idx)
      2'd0: seg_nxt = digit_code(act.ones);
      2'd1: if (!tens_blank) seg_nxt = digit_code(act.tens);
      2'd2: if (!huns_blank) seg_nxt = digit_code(act.huns);
      2'd3: if (act.neg && mag_nz) seg_nxt = SEG_DASH;
      default: seg_nxt = SEG_BLANK;
    endcase
  end

  // Scan counters, pending/active capture and registered display outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= 2'd0;
      pend  <= '0;
      act   <= '0;
      ready <= 1'b1;
      seg   <= SEG_BLANK;
      an    <= 4'b1111;
      err   <= 1'b0;
    end else begin
      cnt <= last_cnt ? '0 : cnt + CNT_W'(1);
      if (last_cnt) idx <= idx + 2'd1;

      // A load on the boundary itself bypasses the pending set.
      if (boundary) begin
        if (load)        act <= in_val;
        else if (!ready) act <= pend;
        ready <= 1'b1;
      end else if (load) begin
        pend  <= in_val;
        ready <= 1'b0;
      end

      seg <= seg_nxt;
      an  <= an_nxt;
      err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan: cycle-accurate frame model plus
// directed loads with hand-computed glyph expectations.
module tb_bcd_display_scan;

  localparam int unsigned S = 4;
  localparam int unsigned F = 4 * S;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] in_ones = 4'd0;
  logic [3:0] in_tens = 4'd0;
  logic [3:0] in_huns = 4'd0;
  logic       in_negative = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       ready;
  logic       err;

  bcd_display_scan #(.SCAN_DIV(S)) dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .in_ones(in_ones), .in_tens(in_tens), .in_huns(in_huns),
    .in_negative(in_negative),
    .seg(seg), .an(an), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int h;
    int t;
    int o;
    bit n;
  } val_t;

  int         m_e = 0;
  val_t       m_act = '{0, 0, 0, 1'b0};
  val_t       m_pend = '{0, 0, 0, 1'b0};
  bit         m_pv = 1'b0;
  logic [6:0] exp_seg = 7'b1111111;
  logic [3:0] exp_an = 4'b1111;
  logic       exp_ready = 1'b1;
  logic       exp_err = 1'b0;
  bit         cmp_en = 1'b0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b exp=%b at t=%0t", name, got, want, $time);
    end
  endtask

  function automatic byte dig(input int d);
    return (d > 9) ? "E" : 8'(48 + d);
  endfunction

  // Character shown at a position for a signed-magnitude value.
  function automatic byte glyph(input int pos, input val_t v);
    case (pos)
      0: return dig(v.o);
      1: return (v.h == 0 && v.t == 0) ? " " : dig(v.t);
      2: return (v.h == 0) ? " " : dig(v.h);
      default: return (v.n && (v.h != 0 || v.t != 0 || v.o != 0)) ? "-" : " ";
    endcase
  endfunction

  function automatic logic [6:0] code_of(input byte c);
    case (c)
      "0": return 7'b1000000;
      "1": return 7'b1111001;
      "2": return 7'b0100100;
      "3": return 7'b0110000;
      "4": return 7'b0011001;
      "5": return 7'b0010010;
      "6": return 7'b0000010;
      "7": return 7'b1111000;
      "8": return 7'b0000000;
      "9": return 7'b0010000;
      "-": return 7'b0111111;
      "E": return 7'b0000110;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic val_t in_now();
    val_t v;
    v.h = int'(in_huns);
    v.t = int'(in_tens);
    v.o = int'(in_ones);
    v.n = in_negative;
    return v;
  endfunction

  // Model: m_e counts edges since reset; edge e shows position ((e-1)/S)%4,
  // and edges with e % F == 0 are frame boundaries.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_e       <= 0;
      m_act     <= '{0, 0, 0, 1'b0};
      m_pend    <= '{0, 0, 0, 1'b0};
      m_pv      <= 1'b0;
      exp_seg   <= 7'b1111111;
      exp_an    <= 4'b1111;
      exp_ready <= 1'b1;
      exp_err   <= 1'b0;
    end else begin
      m_e     <= m_e + 1;
      exp_an  <= 4'b1111 ^ (4'b0001 << ((m_e / S) % 4));
      exp_seg <= code_of(glyph((m_e / S) % 4, m_act));
      exp_err <= (m_act.h > 9) || (m_act.t > 9) || (m_act.o > 9);
      if ((m_e + 1) % F == 0) begin
        if (load)      m_act <= in_now();
        else if (m_pv) m_act <= m_pend;
        m_pv      <= 1'b0;
        exp_ready <= 1'b1;
      end else if (load) begin
        m_pend    <= in_now();
        m_pv      <= 1'b1;
        exp_ready <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("seg", {1'b0, seg}, {1'b0, exp_seg});
      check("an", {4'b0, an}, {4'b0, exp_an});
      check("ready", {7'b0, ready}, {7'b0, exp_ready});
      check("err", {7'b0, err}, {7'b0, exp_err});
    end
  end

  task automatic wait_phase(input int p);
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(F); i++) begin
      if (m_e % F == p) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input int h, input int t, input int o, input bit n);
    in_huns     = 4'(h);
    in_tens     = 4'(t);
    in_ones     = 4'(o);
    in_negative = n;
    load        = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_commit();
    bit seen = 1'b0;
    for (int i = 0; i < int'(2 * F); i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("commit_wait", {7'b0, seen}, 8'd1);
  endtask

  task automatic expect_pos(input int p, input logic [6:0] code, input string name);
    bit seen = 1'b0;
    logic [3:0] want;
    want = 4'b1111 ^ (4'b0001 << p);
    for (int i = 0; i < int'(2 * F); i++) begin
      @(negedge clk);
      if (an === want) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_an_wait"}, {7'b0, seen}, 8'd1);
    check(name, {1'b0, seg}, {1'b0, code});
  endtask

  task automatic expect_frame(input logic [6:0] c0, input logic [6:0] c1,
                              input logic [6:0] c2, input logic [6:0] c3, input string name);
    expect_pos(0, c0, {name, "_ones"});
    expect_pos(1, c1, {name, "_tens"});
    expect_pos(2, c2, {name, "_huns"});
    expect_pos(3, c3, {name, "_sign"});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("first_an", {4'b0, an}, 8'b00001110);
    check("first_seg", {1'b0, seg}, 8'b01000000);
    check("first_ready", {7'b0, ready}, 8'd1);
    repeat (2 * F) @(posedge clk);

    // -150: sign, huns 1, tens 5, ones 0
    wait_phase(5);
    do_load(1, 5, 0, 1'b1);
    @(negedge clk);
    check("ready_low", {7'b0, ready}, 8'd0);
    wait_commit();
    expect_frame(7'b1000000, 7'b0010010, 7'b1111001, 7'b0111111, "m150");
    check("ready_back", {7'b0, ready}, 8'd1);

    // -7: leading zeros blanked
    wait_phase(2);
    do_load(0, 0, 7, 1'b1);
    wait_commit();
    expect_frame(7'b1111000, 7'b1111111, 7'b1111111, 7'b0111111, "m7");

    // negative zero shows plain 0
    wait_phase(7);
    do_load(0, 0, 0, 1'b1);
    wait_commit();
    expect_frame(7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111, "negzero");

    // invalid tens digit
    wait_phase(9);
    do_load(0, 12, 3, 1'b0);
    wait_commit();
    expect_pos(0, 7'b0110000, "bad_ones");
    check("err_set", {7'b0, err}, 8'd1);
    expect_pos(1, 7'b0000110, "bad_tens");
    expect_pos(2, 7'b1111111, "bad_huns");
    wait_phase(3);
    do_load(0, 1, 2, 1'b0);
    wait_commit();
    expect_pos(0, 7'b0100100, "fix_ones");
    check("err_clr", {7'b0, err}, 8'd0);

    // 111 then 222 pending, 333 loaded on the boundary edge itself
    wait_phase(3);
    do_load(1, 1, 1, 1'b0);
    wait_phase(8);
    do_load(2, 2, 2, 1'b0);
    wait_phase(int'(F) - 1);
    check("ready_pending", {7'b0, ready}, 8'd0);
    do_load(3, 3, 3, 1'b0);
    @(negedge clk);
    check("ready_bypass", {7'b0, ready}, 8'd1);
    expect_frame(7'b0110000, 7'b0110000, 7'b0110000, 7'b1111111, "v333");

    // reset mid-frame drops a pending value
    wait_phase(4);
    do_load(4, 4, 4, 1'b1);
    wait_phase(9);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_an", {4'b0, an}, 8'b00001110);
    check("rst_seg", {1'b0, seg}, 8'b01000000);
    check("rst_ready", {7'b0, ready}, 8'd1);
    repeat (2 * F) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
